// File: rtl/key_frame_tx_ctrl_if.sv
// rtl/key_frame_tx_ctrl_if.sv - key source / UART transmitter handshake bundle for key_frame_tx_ctrl
interface key_frame_tx_ctrl_if #(
   parameter int KEY_BYTES = 8
) ();
   logic [8*KEY_BYTES-1:0] key_in;
   logic                   key_valid;
   logic                   key_ready;
   logic                   tx_busy;
   logic                   tx_start;
   logic [7:0]             tx_data;
   logic [7:0]             frame_seq;
   logic                   frame_done;
   logic                   timeout_err;
   logic                   active;

   modport master (
      input  key_in, key_valid, tx_busy,
      output key_ready, tx_start, tx_data, frame_seq, frame_done, timeout_err, active
   );

   modport slave (
      output key_in, key_valid, tx_busy,
      input  key_ready, tx_start, tx_data, frame_seq, frame_done, timeout_err, active
   );
endinterface

// File: rtl/key_frame_tx_ctrl.sv
// rtl/key_frame_tx_ctrl.sv - frames a key as SYNC/seq/key/XOR and feeds it byte-wise to a UART transmitter
module key_frame_tx_ctrl #(
   parameter int         KEY_BYTES   = 8,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         SEQ_WRAP    = 50,
   parameter int         GAP_CYCLES  = 20832,
   parameter int         ACK_TIMEOUT = 16384
) (
   input logic                 clk,
   input logic                 reset,
   key_frame_tx_ctrl_if.master bus
);
   localparam int IDX_W = $clog2(KEY_BYTES + 3);
   localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES + 2);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [7:0]       SEQ_LAST = 8'(SEQ_WRAP - 1);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_FINISH, S_GAP} state_t;

   // With no gap configured, both frame end and abort drop straight back to IDLE.
   localparam state_t S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

   state_t                 state, state_n;
   logic [8*KEY_BYTES-1:0] key_sh;
   logic [IDX_W-1:0]       idx, idx_n;
   logic [7:0]             csum, csum_n, byte_n;
   logic [7:0]             tx_data_q, frame_seq_q;
   logic [TMO_W-1:0]       tmo_cnt;
   logic [GAP_W-1:0]       gap_cnt;
   logic                   timeout_q;
   logic                   accept, tmo_hit, gap_hit, last_byte, abort, advance;
   logic                   key_ready_c, tx_start_c, active_c, frame_done_c;

   assign accept    = (state == S_IDLE) && bus.key_valid;
   assign tmo_hit   = (tmo_cnt == TMO_LAST);
   assign gap_hit   = (gap_cnt == GAP_LAST);
   assign last_byte = (idx == IDX_LAST);
   assign abort     = tmo_hit && (((state == S_SEND) && !bus.tx_busy) ||
                                  ((state == S_WAIT_DONE) && bus.tx_busy));
   assign advance   = (state == S_WAIT_DONE) && !bus.tx_busy && !last_byte;
   assign idx_n     = idx + IDX_W'(1);

   // The SYNC byte (idx 0) is kept out of the checksum.
   assign csum_n    = (idx == '0) ? csum : (csum ^ tx_data_q);

   always_comb begin
      byte_n = key_sh[8*KEY_BYTES-1 -: 8];
      if (idx_n == IDX_W'(1)) begin
         byte_n = frame_seq_q;
      end else if (idx_n == IDX_LAST) begin
         byte_n = csum_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (bus.key_valid) state_n = S_SEND;
         end
         S_SEND: begin
            if (bus.tx_busy)  state_n = S_WAIT_DONE;
            else if (tmo_hit) state_n = S_AFTER;
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) state_n = last_byte ? S_FINISH : S_SEND;
            else if (tmo_hit) state_n = S_AFTER;
         end
         S_FINISH: begin
            state_n = S_AFTER;
         end
         S_GAP: begin
            if (gap_hit) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      key_ready_c  = (state == S_IDLE);
      tx_start_c   = (state == S_SEND);
      active_c     = (state != S_IDLE);
      frame_done_c = (state == S_FINISH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_sh      <= '0;
         idx         <= '0;
         csum        <= '0;
         tx_data_q   <= '0;
         frame_seq_q <= '0;
         tmo_cnt     <= '0;
         gap_cnt     <= '0;
         timeout_q   <= 1'b0;
      end else begin
         timeout_q <= abort;

         // Restarts on every entry into SEND or WAIT_DONE, so each phase gets its own budget.
         if ((state_n != state) || !((state == S_SEND) || (state == S_WAIT_DONE))) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end

         if (state == S_GAP) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
         end else begin
            gap_cnt <= '0;
         end

         if (accept) begin
            key_sh    <= bus.key_in;
            idx       <= '0;
            csum      <= '0;
            tx_data_q <= SYNC_BYTE;
         end else if (advance) begin
            idx       <= idx_n;
            csum      <= csum_n;
            tx_data_q <= byte_n;
            if ((idx_n != IDX_W'(1)) && (idx_n != IDX_LAST)) begin
               key_sh <= key_sh << 8;
            end
         end

         if (state == S_FINISH) begin
            frame_seq_q <= (frame_seq_q == SEQ_LAST) ? 8'd0 : (frame_seq_q + 8'd1);
         end
      end
   end

   assign bus.key_ready   = key_ready_c;
   assign bus.tx_start    = tx_start_c;
   assign bus.active      = active_c;
   assign bus.frame_done  = frame_done_c;
   assign bus.tx_data     = tx_data_q;
   assign bus.frame_seq   = frame_seq_q;
   assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_key_frame_tx_ctrl.sv
// tb/tb_key_frame_tx_ctrl.sv - scoreboard bench for key_frame_tx_ctrl driven by a simple UART model
`timescale 1ns/1ps
module tb_key_frame_tx_ctrl;
   localparam int KB = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   key_frame_tx_ctrl_if #(.KEY_BYTES(KB)) ifc ();

   key_frame_tx_ctrl #(
      .KEY_BYTES(KB), .SYNC_BYTE(8'hA5), .SEQ_WRAP(3), .GAP_CYCLES(4), .ACK_TIMEOUT(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(ifc)
   );

   typedef struct {
      logic [31:0] key;
      logic [7:0]  seq;
      logic [7:0]  csum;
      logic [7:0]  next_seq;
   } vec_t;

   vec_t       tbl [5];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q [$];
   logic [7:0] got_mem [0:255];
   int         got_wr = 0;
   int         got_rd = 0;
   int         busy_dly = 3;
   int         busy_len = 20;
   bit         never_busy = 1'b0;
   int         m_dly = 0;
   int         m_len = 0;
   logic [7:0] cur_byte = 8'h00;
   int         stab_viol = 0;
   int         done_cnt = 0;
   int         tmo_seen = 0;

   // UART model: takes a start only when idle, raises busy busy_dly clocks later for busy_len clocks.
   always @(negedge clk) begin
      if (m_dly > 0) begin
         m_dly--;
         if (m_dly == 0) begin
            ifc.tx_busy = 1'b1;
            m_len = busy_len;
         end
      end else if (m_len > 0) begin
         m_len--;
         if (m_len == 0) ifc.tx_busy = 1'b0;
      end else begin
         ifc.tx_busy = 1'b0;
         if (ifc.tx_start === 1'b1 && !never_busy) begin
            if (got_wr < 256) got_mem[got_wr] = ifc.tx_data;
            got_wr++;
            cur_byte = ifc.tx_data;
            m_dly = busy_dly;
         end
      end
      if ((m_dly > 0 || m_len > 0) && ifc.active === 1'b1 && !reset && ifc.tx_data !== cur_byte)
         stab_viol++;
   end

   always @(negedge clk) begin
      if (ifc.frame_done === 1'b1) done_cnt++;
      if (ifc.timeout_err === 1'b1) tmo_seen++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] frame_csum(input logic [7:0] seq, input logic [31:0] k);
      return seq ^ k[31:24] ^ k[23:16] ^ k[15:8] ^ k[7:0];
   endfunction

   task automatic push_frame(input logic [7:0] seq, input logic [31:0] k, input logic [7:0] cs,
                             input int nb);
      logic [7:0] b [7];
      b[0] = 8'hA5; b[1] = seq;
      b[2] = k[31:24]; b[3] = k[23:16]; b[4] = k[15:8]; b[5] = k[7:0];
      b[6] = cs;
      for (int i = 0; i < nb; i++) exp_q.push_back(b[i]);
   endtask

   task automatic drain(input string tag);
      int pos = 0;
      while (exp_q.size() > 0) begin
         n_vec++;
         if (got_rd < got_wr) begin
            if (got_mem[got_rd] !== exp_q[0]) begin
               n_err++;
               $display("FAIL %s byte%0d: got %h expected %h", tag, pos, got_mem[got_rd], exp_q[0]);
            end
            got_rd++;
         end else begin
            n_err++;
            $display("FAIL %s byte%0d: got none expected %h", tag, pos, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pos++;
      end
      chk({tag, "_extra_bytes"}, got_wr - got_rd, 0);
      got_rd = got_wr;
      chk({tag, "_tx_data_stable"}, stab_viol, 0);
      stab_viol = 0;
   endtask

   task automatic send_key(input logic [31:0] k);
      int n = 0;
      @(negedge clk);
      while (ifc.key_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("send_key_ready_wait", n, 0);
      ifc.key_in    = k;
      ifc.key_valid = 1'b1;
      @(negedge clk);
      ifc.key_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (ifc.active !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk({tag, "_idle_wait"}, n, 0);
   endtask

   task automatic wait_model_idle();
      int n = 0;
      while ((m_dly > 0 || m_len > 0 || ifc.tx_busy === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   initial begin
      int d0, t0, n, n_start, n_gap, base;
      bit seen_done, acc2;

      tbl[0] = '{32'h11223344, 8'h00, 8'h44, 8'h01};
      tbl[1] = '{32'h00000000, 8'h01, 8'h01, 8'h02};
      tbl[2] = '{32'hFFFFFFFF, 8'h02, 8'h02, 8'h00};
      tbl[3] = '{32'hA5A5A5A5, 8'h00, 8'h00, 8'h01};
      tbl[4] = '{32'h01020408, 8'h01, 8'h0E, 8'h02};

      ifc.key_in    = '0;
      ifc.key_valid = 1'b0;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_key_ready", ifc.key_ready, 1);
      chk("rst_tx_start", ifc.tx_start, 0);
      chk("rst_tx_data", ifc.tx_data, 0);
      chk("rst_frame_seq", ifc.frame_seq, 0);
      chk("rst_frame_done", ifc.frame_done, 0);
      chk("rst_timeout_err", ifc.timeout_err, 0);
      chk("rst_active", ifc.active, 0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         d0 = done_cnt;
         t0 = tmo_seen;
         push_frame(tbl[i].seq, tbl[i].key, tbl[i].csum, 7);
         send_key(tbl[i].key);
         if (i == 0) begin
            chk("latency_tx_start", ifc.tx_start, 1);
            chk("accept_active", ifc.active, 1);
            chk("accept_key_ready", ifc.key_ready, 0);
            chk("first_tx_data", ifc.tx_data, 8'hA5);
         end
         wait_idle($sformatf("frame%0d", i));
         drain($sformatf("frame%0d", i));
         chk($sformatf("frame%0d_done_pulses", i), done_cnt - d0, 1);
         chk($sformatf("frame%0d_timeouts", i), tmo_seen - t0, 0);
         chk($sformatf("frame%0d_next_seq", i), ifc.frame_seq, tbl[i].next_seq);
      end

      // Transmitter never acknowledges: abort after ACK_TIMEOUT clocks of SEND.
      never_busy = 1'b1;
      d0 = done_cnt;
      t0 = tmo_seen;
      send_key(32'hDEADBEEF);
      n_start = 0;
      n = 0;
      while (ifc.timeout_err !== 1'b1 && n < 500) begin
         if (ifc.tx_start === 1'b1) n_start++;
         @(negedge clk);
         n++;
      end
      chk("send_tmo_start_cycles", n_start, 64);
      chk("send_tmo_tx_start_low", ifc.tx_start, 0);
      n_gap = 0;
      while (ifc.active === 1'b1 && n_gap < 100) begin
         n_gap++;
         @(negedge clk);
      end
      chk("send_tmo_gap_cycles", n_gap, 4);
      chk("send_tmo_key_ready", ifc.key_ready, 1);
      chk("send_tmo_seq_kept", ifc.frame_seq, 2);
      chk("send_tmo_pulses", tmo_seen - t0, 1);
      chk("send_tmo_no_done", done_cnt - d0, 0);
      never_busy = 1'b0;
      drain("send_tmo");

      // Busy stuck high past ACK_TIMEOUT: abort out of WAIT_DONE after the SYNC byte.
      busy_len = 70;
      d0 = done_cnt;
      t0 = tmo_seen;
      push_frame(8'h02, 32'h0, 8'h0, 1);
      send_key(32'hCAFEF00D);
      n = 0;
      while (ifc.timeout_err !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("wait_tmo_seen", ifc.timeout_err, 1);
      chk("wait_tmo_tx_start_low", ifc.tx_start, 0);
      wait_idle("wait_tmo");
      wait_model_idle();
      chk("wait_tmo_pulses", tmo_seen - t0, 1);
      chk("wait_tmo_no_done", done_cnt - d0, 0);
      chk("wait_tmo_seq_kept", ifc.frame_seq, 2);
      drain("wait_tmo");
      busy_len = 20;

      // key_valid held high with key_in churning; second key only taken once GAP ends.
      d0 = done_cnt;
      push_frame(8'h02, 32'h89ABCDEF, frame_csum(8'h02, 32'h89ABCDEF), 7);
      push_frame(8'h00, 32'h5A5A0F0F, frame_csum(8'h00, 32'h5A5A0F0F), 7);
      @(negedge clk);
      ifc.key_in    = 32'h89ABCDEF;
      ifc.key_valid = 1'b1;
      @(negedge clk);
      n = 0;
      n_gap = 0;
      seen_done = 1'b0;
      acc2 = 1'b0;
      while (!acc2 && n < 2000) begin
         if (ifc.key_ready === 1'b1) begin
            ifc.key_in = 32'h5A5A0F0F;
            acc2 = 1'b1;
         end else begin
            ifc.key_in = $urandom;
            if (seen_done) n_gap++;
            if (ifc.frame_done === 1'b1) seen_done = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      ifc.key_valid = 1'b0;
      chk("hold_valid_gap_before_accept", n_gap, 4);
      wait_idle("hold_valid");
      drain("hold_valid");
      chk("hold_valid_done_pulses", done_cnt - d0, 2);
      chk("hold_valid_next_seq", ifc.frame_seq, 1);

      // Busy follows start after a single clock.
      busy_dly = 1;
      d0 = done_cnt;
      push_frame(8'h01, 32'h13579BDF, frame_csum(8'h01, 32'h13579BDF), 7);
      send_key(32'h13579BDF);
      wait_idle("fast_busy");
      drain("fast_busy");
      chk("fast_busy_done_pulses", done_cnt - d0, 1);
      chk("fast_busy_next_seq", ifc.frame_seq, 2);
      busy_dly = 3;
      wait_model_idle();

      // Reset while byte 3 is being handed over.
      d0 = done_cnt;
      t0 = tmo_seen;
      base = got_wr;
      push_frame(8'h02, 32'h2468ACE0, 8'h00, 4);
      send_key(32'h2468ACE0);
      n = 0;
      while (got_wr - base < 4 && n < 500) begin
         @(negedge clk);
         n++;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_tx_start", ifc.tx_start, 0);
      chk("midrst_active", ifc.active, 0);
      chk("midrst_key_ready", ifc.key_ready, 1);
      chk("midrst_frame_seq", ifc.frame_seq, 0);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      wait_model_idle();
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_no_timeout", tmo_seen - t0, 0);
      drain("midrst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
